// File: rtl/compress_sequencer.sv
// compress_sequencer
// Reduces the SRC_DIM x SRC_DIM 1-bit drawing buffer to a DST_DIM x DST_DIM
// 8-bit image. The source is read in raster order; set pixels are counted
// per BLK x BLK block, and each block's scaled count goes to the compressed
// image RAM once the block's bottom-right pixel has been consumed.
//
// Two stages:
//   issue  : walks (src_x, src_y) and strobes src_re unless the frame buffer
//            stalls.
//   sample : one cycle later consumes src_pix, accumulates it into the
//            column-of-blocks accumulator and, on a block's last pixel,
//            emits the write.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; read counters held at 0
// SCAN  | issuing reads in raster order, frozen while stall is high
// DRAIN | all reads issued; waiting for the final block write to go out
// FIN   | done pulse (busy still high), then back to IDLE
//
// Assumes SRC_DIM <= 256, SRC_DIM a multiple of BLK, BLK >= 8 and
// DST_DIM*DST_DIM <= 1024 so the fixed port widths hold every value.

module compress_sequencer #(
    parameter int SRC_DIM = 224,
    parameter int BLK     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stall,
    output logic [7:0] src_x,
    output logic [7:0] src_y,
    output logic       src_re,
    input  logic       src_pix,
    output logic       dst_we,
    output logic [9:0] dst_addr,
    output logic [7:0] dst_data,
    output logic       busy,
    output logic       done
);

    localparam int DST_DIM = SRC_DIM / BLK;
    localparam int BLK_W   = $clog2(BLK);
    localparam int IDX_W   = $clog2(DST_DIM);
    localparam int SRC_W   = $clog2(SRC_DIM);
    // Accumulator holds 0..BLK*BLK inclusive (a fully set block).
    localparam int CNT_W   = $clog2(BLK * BLK + 1);
    localparam int PROD_W  = CNT_W + 2;

    localparam logic [7:0] COORD_LAST = 8'(SRC_DIM - 1);
    localparam logic [9:0] ADDR_LAST  = 10'(DST_DIM * DST_DIM - 1);
    localparam logic [9:0] ROW_STRIDE = 10'(DST_DIM);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        FIN
    } state_e;

    state_e            state_q;
    logic [7:0]        x_q;
    logic [7:0]        y_q;
    logic              busy_q;
    logic              done_q;

    // Sample stage: coordinates of the read issued last cycle.
    logic              valid_q;
    logic [SRC_W-1:0]  samp_x_q;
    logic [SRC_W-1:0]  samp_y_q;

    // One accumulator per block column; a whole row of blocks is open at once.
    logic [CNT_W-1:0]  acc_q [DST_DIM];

    logic              dst_we_q;
    logic [9:0]        dst_addr_q;
    logic [7:0]        dst_data_q;

    logic              issue;
    logic              last_issue;
    logic [IDX_W-1:0]  blk_x;
    logic [IDX_W-1:0]  blk_y;
    logic              blk_end;
    logic [CNT_W-1:0]  cnt_d;
    logic [PROD_W-1:0] prod_d;
    logic [7:0]        data_d;
    logic [9:0]        addr_d;

    // Read issue is combinational on stall so a busy frame buffer never
    // sees a strobe in the cycle it is busy.
    always_comb begin
        issue      = (state_q == SCAN) && !stall;
        last_issue = issue && (x_q == COORD_LAST) && (y_q == COORD_LAST);
    end

    // Sample-stage arithmetic: pixel count including the incoming pixel,
    // saturating x4 scale (a full block maps to 255), and block address.
    always_comb begin
        blk_x   = samp_x_q[BLK_W +: IDX_W];
        blk_y   = samp_y_q[BLK_W +: IDX_W];
        blk_end = (&samp_x_q[BLK_W-1:0]) && (&samp_y_q[BLK_W-1:0]);
        cnt_d   = acc_q[blk_x] + CNT_W'(src_pix);
        prod_d  = {cnt_d, 2'b00};
        data_d  = (prod_d > PROD_W'(255)) ? 8'hFF : prod_d[7:0];
        addr_d  = 10'(blk_y) * ROW_STRIDE + 10'(blk_x);
    end

    // Sequencer FSM: read counters, busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    x_q <= 8'd0;
                    y_q <= 8'd0;
                    if (start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (last_issue) begin
                        x_q     <= 8'd0;
                        y_q     <= 8'd0;
                        state_q <= DRAIN;
                    end else if (issue) begin
                        if (x_q == COORD_LAST) begin
                            x_q <= 8'd0;
                            y_q <= y_q + 8'd1;
                        end else begin
                            x_q <= x_q + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    // The final block's write is on the outputs this cycle.
                    if (dst_we_q && (dst_addr_q == ADDR_LAST)) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sample stage: track the issued read, accumulate the returned pixel and
    // emit the block write on the block's bottom-right pixel. Pixels are
    // consumed regardless of stall; stall only gates issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            samp_x_q   <= '0;
            samp_y_q   <= '0;
            dst_we_q   <= 1'b0;
            dst_addr_q <= 10'd0;
            dst_data_q <= 8'd0;
            for (int i = 0; i < DST_DIM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            valid_q  <= issue;
            dst_we_q <= 1'b0;
            if (issue) begin
                samp_x_q <= x_q[SRC_W-1:0];
                samp_y_q <= y_q[SRC_W-1:0];
            end
            if (valid_q) begin
                if (blk_end) begin
                    dst_we_q     <= 1'b1;
                    dst_addr_q   <= addr_d;
                    dst_data_q   <= data_d;
                    acc_q[blk_x] <= '0;
                end else begin
                    acc_q[blk_x] <= cnt_d;
                end
            end
        end
    end

    assign src_x    = x_q;
    assign src_y    = y_q;
    assign src_re   = issue;
    assign dst_we   = dst_we_q;
    assign dst_addr = dst_addr_q;
    assign dst_data = dst_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/compress_sequencer.md
Name: compress_sequencer

Overview:
- Sequences the 224x224 1-bit drawing buffer down to the 28x28 8-bit image used by the recognition network.
- Raster-scans the source buffer and counts set pixels in each 8x8 block.
- Writes one scaled intensity per block into the compressed image memory.
- Sits between the compression request logic, which supplies `start`, and the compressed-image RAM feeding the classifier.

Parameters:
- SRC_DIM, 224: source image width and height in pixels.
- BLK, 8: block edge. DST_DIM = SRC_DIM/BLK = 28 is derived, not a parameter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one compression pass; sampled only in IDLE.
- stall  in  1  frame buffer busy; freezes address issue.
- src_x  out  8  source read column, 0..223.
- src_y  out  8  source read row, 0..223.
- src_re  out  1  read strobe for the current src_x/src_y.
- src_pix  in  1  pixel data, valid exactly one cycle after its src_re cycle.
- dst_we  out  1  compressed-memory write strobe.
- dst_addr  out  10  compressed address = by*28 + bx, range 0..783.
- dst_data  out  8  block intensity.
- busy  out  1  high from the start accept until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset values: src_x=0, src_y=0, src_re=0, dst_we=0, dst_addr=0, dst_data=0, busy=0, done=0. The FSM is in IDLE, all 28 accumulators are 0, and the pipeline valid bit is 0.
- States: IDLE, SCAN, DRAIN, FIN.
- IDLE:
  - start=1 -> SCAN, with busy=1 from the next cycle.
  - The src_x/src_y counters are cleared to 0.
- SCAN, issue stage:
  - Each cycle with stall=0: src_re=1 for the current (src_x, src_y).
  - src_x then increments. At 223 it wraps to 0 and src_y increments.
  - Issuing (223,223) -> DRAIN.
  - stall=1: src_re=0 and the counters hold.
- Sample stage:
  - A registered valid bit plus the (x,y) of the issued read follow src_re by one cycle.
  - When valid, src_pix is consumed even if stall=1 that cycle.
  - acc[x>>3] += src_pix. Accumulators are 7-bit, max 64.
- Block completion: when the consumed pixel has x[2:0]=7 and y[2:0]=7, on the same edge:
  - dst_we=1 for one cycle.
  - dst_addr = (y>>3)*28 + (x>>3).
  - dst_data = sat(cnt*4), where cnt = acc + src_pix, so 64 maps to 255 and otherwise cnt<<2.
  - acc[x>>3] is cleared to 0.
- Latency: dst_we rises 2 cycles after the src_re of the block's final pixel, i.e. src_re at cycle n gives dst_we high in cycle n+2.
- Write ordering: raster order by block, addresses 0..783 each written exactly once per pass. No writes occur outside a pass.
- DRAIN: wait for the final sample (223,223) to be consumed and written (address 783), then -> FIN.
- FIN:
  - done=1 for one cycle; busy is still 1 in this cycle.
  - -> IDLE, with busy=0 the cycle after.
- Minimum pass length with stall never asserted: 50176 issue cycles + 2 + 1 (FIN).
- start while busy: ignored. No restart, no queueing.
- start asserted in the same cycle as FIN: ignored; it must be re-asserted in IDLE.
- stall during DRAIN/FIN: no effect.
- rst_n low mid-pass: immediately returns to reset values.
  - No further dst_we and no done.
  - Partial memory contents are left as written.
- Arithmetic:
  - dst_addr uses the 5-bit block row times 28 plus the 5-bit block column, truncated to 10 bits. Values never exceed 783.
  - Accumulators cannot overflow because the maximum is 64.

Test Plan:
- Reset then idle: rst_n low then high, start=0 for 100 cycles -> all outputs 0, no src_re, no dst_we.
- All-ones source, no stall: start pulse -> exactly 784 dst_we with dst_data=255 and addresses 0..783 in order. The first dst_we occurs 2 cycles after src_re of (7,7). done pulses once, 50179 cycles after start acceptance. busy then falls.
- Single block pattern: source pixels set only in x 8..15, y 0..3 (32 pixels) -> address 1 gets dst_data=128, all other addresses 0. Also set one pixel at (223,223) -> address 783 gets 4.
- Stall injection: random stall 30% of cycles on the all-ones pattern -> identical write sequence and data. The read sample after a stall-asserted issue cycle is still consumed; the pass takes longer by exactly the number of stalled SCAN cycles.
- Start while busy and in FIN: extra start pulses mid-SCAN and coincident with done -> no second pass, exactly 784 writes, busy low after FIN.
- Reset mid-pass: assert rst_n low after block 300 has been written -> outputs return to 0 asynchronously. A fresh start then performs a full 784-write pass with accumulators starting from 0 (verified with the single-block pattern).
